// File: rtl/iobuf_turnaround_ctrl_if.sv
// Requester handshake and pad-buffer signals of iobuf_turnaround_ctrl.
// The controller uses the slave modport. The requester and pad side use master.
interface iobuf_turnaround_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             tx_req;
  logic [WIDTH-1:0] tx_data;
  logic             tx_ack;
  logic             rx_req;
  logic             rx_ack;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             busy;
  logic             pad_i;
  logic             pad_t;
  logic             pad_o;

  modport master (
    output tx_req, tx_data, rx_req, pad_o,
    input  tx_ack, rx_ack, rx_data, rx_valid, busy, pad_i, pad_t
  );

  modport slave (
    input  tx_req, tx_data, rx_req, pad_o,
    output tx_ack, rx_ack, rx_data, rx_valid, busy, pad_i, pad_t
  );
endinterface

// File: rtl/iobuf_turnaround_ctrl.sv
// Half-duplex sequencer for one bidirectional pad buffer: it arbitrates TX/RX,
// serialises words LSB first and keeps the pad released for TA cycles around each drive burst.
module iobuf_turnaround_ctrl #(
  parameter int WIDTH = 8,
  parameter int TA    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  iobuf_turnaround_ctrl_if.slave bus
);
  localparam int MAXC = (TA > WIDTH) ? TA : WIDTH;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] TA_LAST = CW'(TA - 1);
  localparam logic [CW-1:0] W_LAST  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [2:0] {IDLE, TA_DRV, DRIVE, TA_REL, LISTEN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             last_tx_q, last_tx_d;
  logic             tx_ack_q, tx_ack_d;
  logic             rx_ack_q, rx_ack_d;
  logic             rx_valid_q, rx_valid_d;
  logic             busy_q, busy_d;
  logic             pad_i_q, pad_i_d;
  logic             pad_t_q, pad_t_d;
  logic [WIDTH-1:0] rx_shifted;
  logic             grant_tx, grant_rx;

  // A tie goes to the side that did not win the previous grant.
  assign grant_tx = bus.tx_req & (~bus.rx_req | ~last_tx_q);
  assign grant_rx = bus.rx_req & (~bus.tx_req | last_tx_q);

  always_comb begin
    rx_shifted            = shift_q >> 1;
    rx_shifted[WIDTH-1]   = bus.pad_o;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    last_tx_d  = last_tx_q;
    tx_ack_d   = 1'b0;
    rx_ack_d   = 1'b0;
    rx_valid_d = 1'b0;
    pad_i_d    = 1'b0;
    pad_t_d    = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (grant_tx) begin
          shift_d   = bus.tx_data;
          tx_ack_d  = 1'b1;
          last_tx_d = 1'b1;
          cnt_d     = TA_LAST;
          state_d   = TA_DRV;
        end else if (grant_rx) begin
          rx_ack_d  = 1'b1;
          last_tx_d = 1'b0;
          cnt_d     = W_LAST;
          state_d   = LISTEN;
        end
      end
      TA_DRV: begin
        if (cnt_q == '0) begin
          cnt_d   = W_LAST;
          pad_t_d = 1'b0;
          pad_i_d = shift_q[0];
          shift_d = shift_q >> 1;
          state_d = DRIVE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      DRIVE: begin
        if (cnt_q == '0) begin
          cnt_d   = TA_LAST;
          state_d = TA_REL;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
          pad_t_d = 1'b0;
          pad_i_d = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      TA_REL: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      LISTEN: begin
        shift_d = rx_shifted;
        if (cnt_q == '0) begin
          rx_data_d  = rx_shifted;
          rx_valid_d = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      last_tx_q  <= 1'b0;
      tx_ack_q   <= 1'b0;
      rx_ack_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      pad_i_q    <= 1'b0;
      pad_t_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      last_tx_q  <= last_tx_d;
      tx_ack_q   <= tx_ack_d;
      rx_ack_q   <= rx_ack_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
      pad_i_q    <= pad_i_d;
      pad_t_q    <= pad_t_d;
    end
  end

  assign bus.tx_ack   = tx_ack_q;
  assign bus.rx_ack   = rx_ack_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.busy     = busy_q;
  assign bus.pad_i    = pad_i_q;
  assign bus.pad_t    = pad_t_q;
endmodule

// File: tb/tb_iobuf_turnaround_ctrl.sv
// Directed bench for iobuf_turnaround_ctrl (WIDTH=8, TA=2): vector table plus
// hand-written reset, contention and back-to-back sequences.
module tb_iobuf_turnaround_ctrl;
  localparam int WIDTH = 8;
  localparam int TA    = 2;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  iobuf_turnaround_ctrl_if #(.WIDTH(WIDTH)) bus ();

  iobuf_turnaround_ctrl #(.WIDTH(WIDTH), .TA(TA)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string      name;
    logic       tx_req;
    logic       rx_req;
    logic [7:0] tx_data;
    logic       pad_o;
    logic       pad_t;
    logic       pad_i;
    logic       tx_ack;
    logic       rx_ack;
    logic       rx_valid;
    logic       busy;
    logic [7:0] rx_data;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic txr, input logic rxr, input logic [7:0] txd,
                     input logic po, input logic pt, input logic pi, input logic ta,
                     input logic ra, input logic rv, input logic bz, input logic [7:0] rd);
    vec_t v;
    v.name = nm; v.tx_req = txr; v.rx_req = rxr; v.tx_data = txd; v.pad_o = po;
    v.pad_t = pt; v.pad_i = pi; v.tx_ack = ta; v.rx_ack = ra; v.rx_valid = rv;
    v.busy = bz; v.rx_data = rd;
    vecs.push_back(v);
  endtask

  function automatic logic [13:0] outs();
    return {bus.pad_t, bus.pad_i, bus.tx_ack, bus.rx_ack, bus.rx_valid, bus.busy, bus.rx_data};
  endfunction

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.busy !== 1'b0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] txw;
    logic [7:0] rxw;
    int         cnt;
    int         grants;
    logic [3:0] order;
    int         overlap;
    logic       rx_active;
    int         ack_e[2];
    int         fall_e[2];
    int         n_ack, n_fall, gap;
    logic       prev_t, seen_rise;

    bus.tx_req = 1'b0; bus.rx_req = 1'b0; bus.tx_data = '0; bus.pad_o = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk("reset_async", {18'd0, outs()}, {18'd0, 2'b10, 4'b0000, 8'h00});
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table: TX of 0xA5 then RX of 0x3C, one edge per entry.
    txw = 8'hA5;
    rxw = 8'h3C;
    add("idle", 0, 0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 8'h00);
    add("tx_grant", 1, 0, txw, 0, 1, 0, 1, 0, 0, 1, 8'h00);
    add("tx_ta1", 0, 0, 8'hFF, 0, 1, 0, 0, 0, 0, 1, 8'h00);
    for (int k = 0; k < 8; k++)
      add($sformatf("tx_bit%0d", k), 0, 0, 8'hFF, 1, 0, txw[k], 0, 0, 0, 1, 8'h00);
    add("tx_rel1", 0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 1, 8'h00);
    add("tx_rel2", 0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 1, 8'h00);
    add("tx_done", 0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 8'h00);
    add("rx_grant", 0, 1, 8'h00, 1, 1, 0, 0, 1, 0, 1, 8'h00);
    for (int k = 0; k < 7; k++)
      add($sformatf("rx_bit%0d", k), 0, 0, 8'h00, rxw[k], 1, 0, 0, 0, 0, 1, 8'h00);
    add("rx_bit7", 0, 0, 8'h00, rxw[7], 1, 0, 0, 0, 1, 0, rxw);
    add("rx_hold", 0, 0, 8'h00, 1, 1, 0, 0, 0, 0, 0, rxw);

    foreach (vecs[i]) begin
      bus.tx_req  = vecs[i].tx_req;
      bus.rx_req  = vecs[i].rx_req;
      bus.tx_data = vecs[i].tx_data;
      bus.pad_o   = vecs[i].pad_o;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_%s", i, vecs[i].name), {18'd0, outs()},
          {18'd0, vecs[i].pad_t, vecs[i].pad_i, vecs[i].tx_ack, vecs[i].rx_ack,
           vecs[i].rx_valid, vecs[i].busy, vecs[i].rx_data});
    end

    // Reset while bit 3 is on the pad.
    bus.tx_req = 1'b1; bus.tx_data = 8'hA5;
    @(posedge clk); #1;
    bus.tx_req = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("mid_drive_bit3", {30'd0, bus.pad_t, bus.pad_i}, 32'd0);
    #2 rst_n = 1'b0;
    #1 chk("mid_drive_reset", {18'd0, outs()}, {18'd0, 2'b10, 4'b0000, 8'h00});
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.tx_ack || bus.rx_valid || bus.busy || !bus.pad_t) cnt++;
    end
    chk("after_reset_quiet", cnt, 0);

    // Reset part way through a receive: the partial word must be dropped.
    bus.rx_req = 1'b1; bus.pad_o = 1'b1;
    @(posedge clk); #1;
    bus.rx_req = 1'b0;
    repeat (3) @(posedge clk);
    do_reset();
    cnt = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.rx_valid) cnt++;
    end
    chk("rx_abort_no_valid", cnt, 0);
    chk("rx_abort_data", {24'd0, bus.rx_data}, 32'd0);

    // Contention from reset: both requesters re-assert after their ACK.
    do_reset();
    bus.tx_req = 1'b1; bus.rx_req = 1'b1; bus.tx_data = 8'h96;
    grants = 0; order = '0; overlap = 0; rx_active = 1'b0; cnt = 0;
    while (grants < 4 && cnt < 200) begin
      bus.pad_o = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cnt++;
      if (bus.tx_ack && bus.rx_ack) overlap++;
      if (bus.rx_valid) rx_active = 1'b0;
      if (bus.rx_ack) rx_active = 1'b1;
      if (!bus.pad_t && rx_active) overlap++;
      if (bus.tx_ack) begin order = {order[2:0], 1'b1}; grants++; end
      if (bus.rx_ack) begin order = {order[2:0], 1'b0}; grants++; end
      bus.tx_req = !bus.tx_ack;
      bus.rx_req = !bus.rx_ack;
    end
    chk("contention_grants", grants, 4);
    chk("contention_order", {28'd0, order}, 32'b1010);
    chk("contention_overlap", overlap, 0);
    bus.tx_req = 1'b0; bus.rx_req = 1'b0;
    wait_idle("contention_idle");

    // Back-to-back TX with the second request held through the first burst.
    @(posedge clk); #1;
    bus.tx_req = 1'b1; bus.tx_data = 8'hC3;
    n_ack = 0; n_fall = 0; gap = 0; prev_t = 1'b1; seen_rise = 1'b0;
    ack_e[0] = -1; ack_e[1] = -1; fall_e[0] = -1; fall_e[1] = -1;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk); #1;
      if (bus.tx_ack && n_ack < 2) begin
        ack_e[n_ack] = e;
        n_ack++;
        if (n_ack == 2) bus.tx_req = 1'b0;
      end
      if (prev_t && !bus.pad_t && n_fall < 2) begin
        fall_e[n_fall] = e;
        n_fall++;
      end
      if (!prev_t && bus.pad_t) seen_rise = 1'b1;
      if (seen_rise && n_fall < 2 && bus.pad_t) gap++;
      prev_t = bus.pad_t;
    end
    bus.tx_req = 1'b0;
    chk("b2b_ack0", ack_e[0], 0);
    chk("b2b_ack1", ack_e[1], 13);
    chk("b2b_fall0", fall_e[0], 2);
    chk("b2b_fall1", fall_e[1], 15);
    chk("b2b_gap", gap, 5);
    wait_idle("b2b_idle");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
